// File: rtl/uart_tx_slave.sv
// uart_tx_slave: memory-mapped 8N1 UART transmitter behind the SoC valid/ready
// interconnect. Byte writes to TXDATA fill a small FIFO that a bit-serial
// engine drains LSB first. STATUS and DIVISOR are readable. A push into a full
// FIFO holds the bus response until the transmitter frees an entry.
module uart_tx_slave #(
   parameter int          fifo_depth_log2 = 3,
   parameter logic [15:0] div_reset       = 16'd434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_valid,
   input  logic        uart_instr,
   input  logic [31:0] uart_addr,
   input  logic [31:0] uart_wdata,
   input  logic [3:0]  uart_wstrb,
   output logic [31:0] uart_rdata,
   output logic        uart_ready,
   output logic        uart_tx
);

   localparam int depth = 2 ** fifo_depth_log2;
   localparam logic [fifo_depth_log2:0] full_count = {1'b1, {fifo_depth_log2{1'b0}}};

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;

   typedef enum logic [1:0] {BUS_IDLE, BUS_RESP, BUS_STALL} bus_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   // FIFO
   logic [7:0]                 fifo_mem [depth];
   logic [fifo_depth_log2-1:0] wr_ptr, rd_ptr;
   logic [fifo_depth_log2:0]   fifo_count;
   logic                       fifo_full, fifo_empty;
   logic                       push, pop;
   logic [7:0]                 push_data;

   // Bus side
   bus_state_t  bus_state, bus_state_d;
   logic [31:0] rd_mux, rdata_q;
   logic [7:0]  held_byte;
   logic [15:0] div_q;
   logic [1:0]  div_we;
   logic        capture, hold_we;
   logic        is_write, is_push;
   logic [1:0]  reg_sel;

   // Transmitter
   tx_state_t   tx_state, tx_state_d;
   logic [15:0] bit_cnt, bit_cnt_d;
   logic [15:0] bit_div, bit_div_d;
   logic [2:0]  bit_idx, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        tx_busy;

   // Only the register-select bits of the offset and the low two data lanes matter.
   logic unused_ok;
   assign unused_ok = &{1'b0, uart_addr[31:4], uart_addr[1:0], uart_wdata[31:16]};

   assign fifo_full  = (fifo_count == full_count);
   assign fifo_empty = (fifo_count == '0);
   assign tx_busy    = (tx_state != TX_IDLE);

   assign reg_sel  = uart_addr[3:2];
   assign is_write = (uart_wstrb != 4'd0) && !uart_instr;
   assign is_push  = is_write && (reg_sel == REG_TXDATA) && uart_wstrb[0];

   // FIFO storage, written only on push.
   // NOTE: the storage array has no reset; pointers and count decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= push_data;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Register read mux; reflects state before the current access.
   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_STATUS: begin
            rd_mux[0]                        = fifo_full;
            rd_mux[1]                        = fifo_empty;
            rd_mux[2]                        = tx_busy;
            rd_mux[8 +: fifo_depth_log2 + 1] = fifo_count;
         end
         REG_DIVISOR: rd_mux[15:0] = div_q;
         default: ;
      endcase
   end

   // Bus FSM next state: accept in IDLE, hold a full-FIFO push in STALL, answer in RESP.
   always_comb begin
      bus_state_d = bus_state;
      push        = 1'b0;
      push_data   = uart_wdata[7:0];
      div_we      = 2'b00;
      capture     = 1'b0;
      hold_we     = 1'b0;
      case (bus_state)
         BUS_IDLE: begin
            if (uart_valid) begin
               capture = 1'b1;
               if (is_push && fifo_full) begin
                  hold_we     = 1'b1;
                  bus_state_d = BUS_STALL;
               end else begin
                  push        = is_push;
                  bus_state_d = BUS_RESP;
                  if (is_write && (reg_sel == REG_DIVISOR)) div_we = uart_wstrb[1:0];
               end
            end
         end
         BUS_RESP: bus_state_d = BUS_IDLE;
         BUS_STALL: begin
            // A pop has freed an entry by the time full drops; push the held byte now.
            if (!fifo_full) begin
               push        = 1'b1;
               push_data   = held_byte;
               bus_state_d = BUS_RESP;
            end
         end
         default: bus_state_d = BUS_IDLE;
      endcase
   end

   // Bus-side registers: FSM state, captured read data, held byte, divisor lanes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_state <= BUS_IDLE;
         rdata_q   <= '0;
         held_byte <= '0;
         div_q     <= div_reset;
      end else begin
         bus_state <= bus_state_d;
         if (capture)   rdata_q     <= rd_mux;
         if (hold_we)   held_byte   <= uart_wdata[7:0];
         if (div_we[0]) div_q[7:0]  <= uart_wdata[7:0];
         if (div_we[1]) div_q[15:8] <= uart_wdata[15:8];
      end
   end

   assign uart_ready = (bus_state == BUS_RESP);
   assign uart_rdata = uart_ready ? rdata_q : 32'd0;

   // Transmitter next state: each of start, 8 data and stop bits lasts bit_div cycles.
   always_comb begin
      tx_state_d = tx_state;
      bit_cnt_d  = bit_cnt;
      bit_div_d  = bit_div;
      bit_idx_d  = bit_idx;
      shift_d    = shift_q;
      pop        = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_d    = fifo_mem[rd_ptr];
               // The divisor is frozen per frame; zero would mean no bit time, so treat it as one.
               bit_div_d  = (div_q == 16'd0) ? 16'd1 : div_q;
               bit_cnt_d  = bit_div_d - 16'd1;
               tx_state_d = TX_START;
            end
         end
         default: begin
            if (bit_cnt != 16'd0) begin
               bit_cnt_d = bit_cnt - 16'd1;
            end else begin
               bit_cnt_d = bit_div - 16'd1;
               case (tx_state)
                  TX_START: begin
                     tx_state_d = TX_DATA;
                     bit_idx_d  = 3'd0;
                  end
                  TX_DATA: begin
                     if (bit_idx == 3'd7) begin
                        tx_state_d = TX_STOP;
                     end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx + 3'd1;
                     end
                  end
                  default: tx_state_d = TX_IDLE;
               endcase
            end
         end
      endcase
      // Line level follows the state being entered so the output flop lines up with it.
      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // Transmitter registers; reset aborts any frame and returns the line to idle-high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state <= TX_IDLE;
         bit_cnt  <= '0;
         bit_div  <= 16'd1;
         bit_idx  <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         tx_state <= tx_state_d;
         bit_cnt  <= bit_cnt_d;
         bit_div  <= bit_div_d;
         bit_idx  <= bit_idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   assign uart_tx = tx_q;

endmodule

// File: doc/uart_tx_slave.md
Name: uart_tx_slave

Overview:
- Memory-mapped UART transmitter that responds to the valid/ready bus used by the SoC interconnect. It sits behind the interconnect as a slave, alongside bram, print and clint.
- Accepts byte writes into a TX FIFO and serializes them 8N1, LSB first, on uart_tx.
- Returns status and divisor on reads.
- Addresses arrive as offsets; the interconnect has already subtracted the base.

Parameters:
- fifo_depth_log2, 3, FIFO holds 2**fifo_depth_log2 bytes.
- div_reset, 434, reset value of the baud divisor in clk cycles per bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; rst==0 resets.
- uart_valid  in  1  request strobe, single-cycle pulse.
- uart_instr  in  1  fetch flag; the access is treated as an ordinary read.
- uart_addr  in  32  byte offset; bits [3:2] decode the register.
- uart_wdata  in  32  write data.
- uart_wstrb  in  4  byte strobes; nonzero means write.
- uart_rdata  out  32  read data, valid only while uart_ready=1, else 0.
- uart_ready  out  1  one-cycle response pulse.
- uart_tx  out  1  serial line, idle high.

Behaviour:
- Reset (async, rst==0):
  - uart_ready=0, uart_rdata=0, uart_tx=1.
  - FIFO empty, divisor=div_reset, TX FSM=IDLE, bus FSM=IDLE.
  - Reset mid-frame aborts the frame immediately and drives uart_tx=1. Any pending response is dropped.
- Register map (offset):
  - 0x0 TXDATA: a write with wstrb[0]=1 pushes wdata[7:0]. A write with wstrb[0]=0 is ignored but still acknowledged. Reads return 0.
  - 0x4 STATUS, read-only:
    - bit0 = full
    - bit1 = empty
    - bit2 = busy (TX FSM not IDLE)
    - bits[8+fifo_depth_log2:8] = FIFO count
    - other bits 0
  - 0x8 DIVISOR, read/write: bits[15:0]; only wstrb[1:0] lanes update. Reads zero-extend.
  - 0xC: reads return 0, writes are ignored.
- Bus FSM states: IDLE, RESP, STALL.
  - IDLE: sample uart_valid=1 at edge T.
    - Normal access: go to RESP, perform the write at T, and assert ready in cycle T+1 with rdata captured at T. Status reflects state before the access.
    - TXDATA push while FIFO is full: capture the byte and go to STALL.
  - RESP: uart_ready=1 for exactly one cycle, then IDLE.
  - STALL: wait for a pop. In the cycle after the pop, push the held byte and go to RESP. Ready comes 1 cycle after the push.
  - uart_valid while not IDLE is ignored. Requesters do not overlap, per the bus contract.
- FIFO:
  - Circular buffer; pointers wrap modulo depth.
  - Simultaneous push and pop leaves count unchanged.
  - Pop occurs only from the TX FSM.
  - No overflow is possible because of the STALL state. No underflow is possible because the FSM pops only when not empty.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into a shift register and latch the divisor; divisor value 0 is latched as 1. Go to START with uart_tx=0.
  - Bit timing: each state holds uart_tx for exactly div cycles, using a 16-bit counter from div-1 down to 0.
  - DATA: 8 bits, LSB first, with a 3-bit bit counter.
  - STOP: uart_tx=1 for div cycles.
  - After STOP, go back to IDLE. A non-empty FIFO starts the next frame in the following cycle, so there is 1 idle cycle between frames.
  - Frame length = 10*div cycles plus 1 pop cycle.
- Divisor writes during a frame affect only the next frame.

Test Plan:
- Reset, then read 0x4 → ready exactly 1 cycle after valid, rdata=0x00000002, uart_tx=1.
- Write 0x8 wdata=4, wstrb=0x3; write 0x0 wdata=0x55 → uart_tx=0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. Busy reads 1 during the frame and 0 after.
- Divisor 4: write 9 bytes 0x00..0x08 back-to-back → the first 9 writes are acknowledged in 1 cycle each. The FIFO holds bytes 1..8 (byte 0 was popped) with status count=8 and full=1. A 10th write stalls until the pop of byte 1, and ready arrives 2 cycles after that pop. All 10 bytes appear on uart_tx in order.
- Write 0x0 with wstrb=0x2 → acknowledged, FIFO count unchanged, uart_tx stays 1.
- Divisor 0 → bit time is 1 cycle and the frame is 10 cycles.
- Assert rst=0 during DATA bit 3 → uart_tx=1 asynchronously. After release, STATUS=0x2 and divisor reads 434.
